// File: rtl/stereo_disp_sched.sv
// Stereo disparity scheduler: reads the left and right calc strip buffers and runs a
// sum-of-absolute-differences block match over MAX_DISP disparities, reporting the best one.
module stereo_disp_sched #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 3,
    parameter int WIN      = 16,
    parameter int MAX_DISP = 64,
    parameter int RD_LAT   = 2,
    parameter int SAD_W    = DATA_W + $clog2(WIN)
) (
    input  logic                        sysclk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base,
    output logic [ADDR_W-1:0]           rdaddrl,
    output logic                        rdenl,
    input  logic [DATA_W-1:0]           datal,
    output logic [ADDR_W-1:0]           rdaddrr,
    output logic                        rdenr,
    input  logic [DATA_W-1:0]           datar,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(MAX_DISP)-1:0] disparity,
    output logic [SAD_W-1:0]            min_sad
);
    localparam int DISP_W = $clog2(MAX_DISP);
    localparam int I_W    = $clog2(WIN);
    localparam int LAT_W  = $clog2(RD_LAT) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Tag travelling alongside each address pair until its read data returns.
    typedef struct packed {
        logic              valid;
        logic              first;
        logic              last;
        logic [DISP_W-1:0] d;
    } tag_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q;
    logic [I_W-1:0]      i_q, i_nxt;
    logic [DISP_W-1:0]   d_q, d_nxt;
    logic                rden_q;
    logic                last_i, last_pair;
    logic [LAT_W-1:0]    drain_q;
    tag_t                cur_tag, tl;
    tag_t                pipe_q [RD_LAT];
    logic [DATA_W:0]     diff_lr, diff_rl, abs_x;
    logic [SAD_W-1:0]    sad_q, sad_sum, best_sad_q, best_sad_nxt;
    logic [DISP_W-1:0]   best_d_q, best_d_nxt;
    logic                better;

    assign rdenl = rden_q;
    assign rdenr = rden_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

    assign last_i    = (i_q == I_W'(WIN - 1));
    assign last_pair = last_i && (d_q == DISP_W'(MAX_DISP - 1));
    assign i_nxt     = last_i ? '0 : i_q + I_W'(1);
    assign d_nxt     = last_i ? d_q + DISP_W'(1) : d_q;
    assign cur_tag   = '{valid: rden_q, first: (i_q == '0), last: last_i, d: d_q};
    assign tl        = pipe_q[RD_LAT-1];

    // Absolute difference in DATA_W+1 bits; the sign bit picks which subtraction to keep.
    assign diff_lr = {1'b0, datal} - {1'b0, datar};
    assign diff_rl = {1'b0, datar} - {1'b0, datal};
    assign abs_x   = diff_lr[DATA_W] ? diff_rl : diff_lr;
    assign sad_sum = tl.first ? SAD_W'(abs_x) : sad_q + SAD_W'(abs_x);

    // Strict improvement only, so ties keep the lower disparity; d = 0 always seeds.
    assign better       = tl.valid && tl.last && ((tl.d == '0) || (sad_sum < best_sad_q));
    assign best_sad_nxt = better ? sad_sum : best_sad_q;
    assign best_d_nxt   = better ? tl.d : best_d_q;

    always_ff @(posedge sysclk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_pair) state_d = DRAIN;
            DRAIN:   if (drain_q == LAT_W'(RD_LAT - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            // NOTE: the tag pipeline and accumulators are cleared too so a reset discards in-flight reads.
            base_q     <= '0;
            rdaddrl    <= '0;
            rdaddrr    <= '0;
            rden_q     <= 1'b0;
            i_q        <= '0;
            d_q        <= '0;
            drain_q    <= '0;
            sad_q      <= '0;
            best_sad_q <= '0;
            best_d_q   <= '0;
            disparity  <= '0;
            min_sad    <= '0;
            for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    base_q  <= base;
                    rdaddrl <= base;
                    rdaddrr <= base;
                    rden_q  <= 1'b1;
                    i_q     <= '0;
                    d_q     <= '0;
                end
                RUN: if (last_pair) begin
                    rden_q  <= 1'b0;
                    rdaddrl <= '0;
                    rdaddrr <= '0;
                    drain_q <= '0;
                end else begin
                    i_q     <= i_nxt;
                    d_q     <= d_nxt;
                    rdaddrr <= base_q + ADDR_W'(i_nxt);
                    rdaddrl <= base_q + ADDR_W'(i_nxt) + ADDR_W'(d_nxt);
                end
                DRAIN:   drain_q <= drain_q + LAT_W'(1);
                default: ;
            endcase

            pipe_q[0] <= cur_tag;
            for (int k = 1; k < RD_LAT; k++) pipe_q[k] <= pipe_q[k-1];

            if (tl.valid) sad_q <= sad_sum;
            best_sad_q <= best_sad_nxt;
            best_d_q   <= best_d_nxt;

            // The final window's compare lands on the same edge that enters DONE.
            if (state_q == DRAIN && state_d == DONE) begin
                disparity <= best_d_nxt;
                min_sad   <= best_sad_nxt;
            end
        end
    end
endmodule

// File: doc/stereo_disp_sched.md
Name: stereo_disp_sched

Overview:
- Sequences reads from the left and right calc strip buffers (dataram instances: 2048 x 3-bit, 11-bit address) after both cameras finish a strip.
- Computes a sum-of-absolute-differences (SAD) block match over a disparity range and reports the best disparity for the distance-estimation stage.
- Sits between the two dataram read ports and the distance/display logic. It owns rdaddress/rden on both calc RAMs.

Parameters:
- ADDR_W, 11, calc RAM address width; all address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 3, pixel width on datal/datar.
- WIN, 16, match window length in pixels.
- MAX_DISP, 64, number of disparities tested (0..MAX_DISP-1).
- RD_LAT, 2, calc RAM read latency in cycles.
- SAD_W, DATA_W+$clog2(WIN), accumulator width; 7 at defaults, max SAD 112.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; both strip buffers are full. Accepted only in IDLE.
- base  in  ADDR_W  window start address; sampled when start is accepted.
- rdaddrl  out  ADDR_W  left calc RAM read address (registered).
- rdenl  out  1  left calc RAM read enable.
- datal  in  DATA_W  left calc RAM q.
- rdaddrr  out  ADDR_W  right calc RAM read address (registered).
- rdenr  out  1  right calc RAM read enable.
- datar  in  DATA_W  right calc RAM q.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle pulse; result outputs are valid.
- disparity  out  $clog2(MAX_DISP)  best disparity; held until the next done.
- min_sad  out  SAD_W  SAD of the best disparity; held until the next done.

Behaviour:
- Reset values: all outputs are 0 and the state is IDLE. Reset in any state aborts the job immediately with no done pulse, discards in-flight read data, and clears the accumulators.
- States: IDLE -> RUN (on start) -> DRAIN (last address issued) -> DONE (last data compared) -> IDLE (unconditional, 1 cycle).
- IDLE:
  - rdenl = rdenr = 0; addresses hold at 0.
  - On start: latch base; load rdaddrr = base and rdaddrl = base; assert both rden; go to RUN.
- RUN:
  - One address pair per cycle, loop order d outer (0..MAX_DISP-1), i inner (0..WIN-1).
  - rdaddrr = base+i and rdaddrl = base+i+d, both mod 2^ADDR_W.
  - N = WIN*MAX_DISP pairs in total, issued in cycles 1..N after the start edge.
  - After pair N, rden deasserts and the state moves to DRAIN.
- Read data: data for addresses driven in cycle n is valid on datal/datar during cycle n+RD_LAT and is sampled at the end of that cycle. The valid/last-of-window/last-overall tags follow a RD_LAT-deep shift pipeline.
- Accumulate: sad += |datal - datar|, computed in unsigned DATA_W+1 arithmetic. The accumulator restarts (loads the first term) at i = 0 of each d.
- Compare on the last i of each d:
  - If d = 0 or sad < best_sad (strict), update best_sad and best_d.
  - On a tie the lower d is kept.
- DRAIN:
  - Waits RD_LAT cycles for in-flight data, then moves to DONE.
  - The final compare is performed on entry to DONE.
- DONE:
  - disparity = best_d, min_sad = best_sad, done = 1, busy = 1.
- Latency: at defaults done is asserted in cycle N+RD_LAT+1 = 1027 after the start edge.
- Boundary cases:
  - start while busy is ignored, including start in the DONE cycle.
  - base+i+d overflow wraps to 0.
  - start held high re-triggers only after returning to IDLE.

Test Plan:
- Bench RAM model, RD_LAT=2, left[a]=right[a-13] (LFSR content), base=960, start pulse → done exactly in cycle 1027, disparity=13, min_sad=0, busy high over cycles 1..1027.
- left[a]=right[a]=a[2:0] (period 8), base=0 → SAD=0 at d=0,8,16…; tie rule gives disparity=0, min_sad=0.
- right all 0, left all 7 → disparity=0, min_sad=112 (no strict improvement after d=0).
- base=2040, left[a]=right[a-20] → rdaddrl wraps past 2047 to 0, and the trace at d=20, i=0 shows rdaddrl=12, rdaddrr=2040; result disparity=20, min_sad=0.
- Address trace check: cycles 1..3 show (rdaddrr,rdaddrl) = (base,base), (base+1,base+1), (base+2,base+2); cycle 17 shows (base,base+1); rden low from cycle 1025 on.
- start asserted again at cycle 400 → ignored. reset at cycle 500 → next cycle busy=0, rden=0, outputs 0, no done pulse. A fresh start then yields the correct result in cycle 1027 after it.
